// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath: load extraction, source select, register file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int         XLEN    = 32,
    parameter logic [1:0] WB_ALU  = 2'd0,
    parameter logic [1:0] WB_LOAD = 2'd1,
    parameter logic [1:0] WB_PC4  = 2'd2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid,
    input  logic            mem_reg_wen,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_word,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            wb_stall,
    input  logic            wb_flush,
    output logic            W_en,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] Wr_data,
    output logic            wb_load_err,
    output logic [63:0]     retire_count
);

    typedef struct packed {
        logic            valid;
        logic            reg_wen;
        logic [4:0]      rd;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] load_word;
        logic [XLEN-1:0] pc_plus4;
    } wb_fields_t;

    wb_fields_t wb_reg;
    wb_fields_t wb_next;

    // Flush wins over stall so a squashed instruction never re-presents a write.
    always_comb begin
        wb_next = wb_reg;
        if (wb_flush) begin
            wb_next = '0;
        end else if (!wb_stall) begin
            wb_next.valid      = mem_valid;
            wb_next.reg_wen    = mem_reg_wen;
            wb_next.rd         = mem_rd;
            wb_next.wb_sel     = mem_wb_sel;
            wb_next.funct3     = mem_funct3;
            wb_next.alu_result = mem_alu_result;
            wb_next.load_word  = mem_load_word;
            wb_next.pc_plus4   = mem_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg <= '0;
        end else begin
            wb_reg <= wb_next;
        end
    end

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = wb_reg.load_word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = wb_reg.load_word[16*gi +: 16];
        end
    endgenerate

    logic [1:0]      load_off;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_data;
    logic            load_reserved;

    assign load_off = wb_reg.alu_result[1:0];
    assign sel_byte = byte_lane[load_off];
    assign sel_half = half_lane[load_off[1]];

    always_comb begin
        load_data     = '0;
        load_reserved = 1'b0;
        case (wb_reg.funct3)
            3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            3'b010:  load_data = wb_reg.load_word;
            default: load_reserved = 1'b1;
        endcase
    end

    assign wb_load_err = wb_reg.valid & (wb_reg.wb_sel == WB_LOAD) & load_reserved;

    always_comb begin
        Wr_data = '0;
        case (wb_reg.wb_sel)
            WB_ALU:  Wr_data = wb_reg.alu_result;
            WB_LOAD: Wr_data = load_data;
            WB_PC4:  Wr_data = wb_reg.pc_plus4;
            default: Wr_data = '0;
        endcase
    end

    assign Rd   = wb_reg.rd;
    assign W_en = wb_reg.valid & wb_reg.reg_wen & (wb_reg.rd != 5'd0) & ~wb_load_err;

`ifdef WB_RETIRE_CNT_EN
    // An instruction leaves WB whenever the register is not holding it (flush also releases it).
    logic [63:0] retire_count_reg;
    logic [63:0] retire_count_next;

    always_comb begin
        retire_count_next = retire_count_reg;
        if (wb_reg.valid && (wb_flush || !wb_stall)) begin
            retire_count_next = retire_count_reg + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_reg <= 64'd0;
        end else begin
            retire_count_reg <= retire_count_next;
        end
    end

    assign retire_count = retire_count_reg;
`else
    assign retire_count = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a behavioural write-back model.
// Retire-counter expectations follow WB_RETIRE_CNT_EN.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_reg_wen;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_word;
    logic [31:0] mem_pc_plus4;
    logic        wb_stall;
    logic        wb_flush;
    logic        W_en;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;
    logic        wb_load_err;
    logic [63:0] retire_count;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_reg_wen    (mem_reg_wen),
        .mem_rd         (mem_rd),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_load_word  (mem_load_word),
        .mem_pc_plus4   (mem_pc_plus4),
        .wb_stall       (wb_stall),
        .wb_flush       (wb_flush),
        .W_en           (W_en),
        .Rd             (Rd),
        .Wr_data        (Wr_data),
        .wb_load_err    (wb_load_err),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently sitting in WB.
    logic        m_valid;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu;
    logic [31:0] m_word;
    logic [31:0] m_pc;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] alu,
                                               input logic [31:0] word);
        int unsigned b;
        int unsigned h;
        b = (word >> (8 * alu[1:0])) & 32'hFF;
        h = (word >> (16 * alu[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b - 256) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h - 65536) : h;
            3'd5:    return h;
            3'd2:    return word;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_err();
        return m_valid && (m_sel == 2'd1) && (m_f3 == 3'd3 || m_f3 == 3'd6 || m_f3 == 3'd7);
    endfunction

    function automatic logic [31:0] model_data();
        if (m_sel == 2'd0) return m_alu;
        if (m_sel == 2'd1) return model_load(m_f3, m_alu, m_word);
        if (m_sel == 2'd2) return m_pc;
        return 32'd0;
    endfunction

    task automatic model_reset();
        {m_valid, m_wen, m_rd, m_sel, m_f3} = '0;
        {m_alu, m_word, m_pc} = '0;
        m_cnt = 64'd0;
    endtask

    task automatic check_all(input string tag);
        logic exp_wen;
        exp_wen = m_valid && m_wen && (m_rd != 5'd0) && !model_err();
        check({tag, ".wen"}, 64'(W_en), 64'(exp_wen));
        check({tag, ".rd"}, 64'(Rd), 64'(m_rd));
        check({tag, ".data"}, 64'(Wr_data), 64'(model_data()));
        check({tag, ".err"}, 64'(wb_load_err), 64'(model_err()));
        check({tag, ".cnt"}, retire_count, m_cnt);
        $display("txn %-10s W_en=%0b Rd=%0d Wr_data=%08h err=%0b retired=%0d",
                 tag, W_en, Rd, Wr_data, wb_load_err, retire_count);
    endtask

    task automatic cycle(input logic v, input logic wen, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] word, input logic [31:0] pc,
                         input logic st, input logic fl, input string tag);
        mem_valid = v;   mem_reg_wen = wen; mem_rd = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_load_word = word; mem_pc_plus4 = pc;
        wb_stall = st;   wb_flush = fl;
        @(posedge clk);
`ifdef WB_RETIRE_CNT_EN
        if (m_valid && (fl || !st)) m_cnt = m_cnt + 64'd1;
`endif
        if (fl) begin
            {m_valid, m_wen, m_rd, m_sel, m_f3} = '0;
            {m_alu, m_word, m_pc} = '0;
        end else if (!st) begin
            m_valid = v; m_wen = wen; m_rd = rd; m_sel = sel;
            m_f3 = f3;   m_alu = alu; m_word = word; m_pc = pc;
        end
        #1;
        check_all(tag);
    endtask

    localparam logic [31:0] LDW = 32'h80FF_7F01;

    initial begin
        logic [31:0] held_data;
        logic [63:0] held_cnt;

        rst_n = 1'b0;
        {mem_valid, mem_reg_wen, mem_rd, mem_wb_sel, mem_funct3} = '0;
        {mem_alu_result, mem_load_word, mem_pc_plus4} = '0;
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        cycle(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0, "alu");
        check("alu.lit", 64'(Wr_data), 64'h1234_5678);
        cycle(1, 1, 5'd0, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0, "alu_x0");
        check("alu_x0.lit", 64'(W_en), 64'd0);
        cycle(1, 1, 5'd7, 2'd1, 3'd0, 32'h3, LDW, 32'h0, 0, 0, "lb3");
        check("lb3.lit", 64'(Wr_data), 64'hFFFF_FF80);
        cycle(1, 1, 5'd7, 2'd1, 3'd4, 32'h2, LDW, 32'h0, 0, 0, "lbu2");
        check("lbu2.lit", 64'(Wr_data), 64'h0000_00FF);
        cycle(1, 1, 5'd7, 2'd1, 3'd1, 32'h2, LDW, 32'h0, 0, 0, "lh2");
        check("lh2.lit", 64'(Wr_data), 64'hFFFF_80FF);
        cycle(1, 1, 5'd7, 2'd1, 3'd5, 32'h0, LDW, 32'h0, 0, 0, "lhu0");
        check("lhu0.lit", 64'(Wr_data), 64'h0000_7F01);
        cycle(1, 1, 5'd7, 2'd1, 3'd2, 32'h1, LDW, 32'h0, 0, 0, "lw");
        check("lw.lit", 64'(Wr_data), 64'h80FF_7F01);
        cycle(1, 1, 5'd7, 2'd1, 3'd3, 32'h0, LDW, 32'h0, 0, 0, "lres");
        check("lres.lit_wen", 64'(W_en), 64'd0);
        check("lres.lit_err", 64'(wb_load_err), 64'd1);
        cycle(1, 1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0104, 0, 0, "jal");
        check("jal.lit", 64'(Wr_data), 64'h0000_0104);

        held_data = Wr_data;
        held_cnt  = retire_count;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 5'($urandom), 2'd0, 3'd0, $urandom, $urandom, $urandom, 1, 0, "stall");
            check("stall.hold", 64'(Wr_data), 64'(held_data));
            check("stall.wen", 64'(W_en), 64'd1);
        end
        cycle(1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 1, "flst");
        check("flst.wen", 64'(W_en), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("flst.cnt", retire_count, held_cnt + 64'd1);
`else
        check("flst.cnt", retire_count, 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 5) != 0, $urandom % 2, 5'($urandom), 2'($urandom), 3'($urandom),
                  $urandom, $urandom, $urandom, ($urandom % 5) == 0, ($urandom % 10) == 0, "rand");
            if (i == 200) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rst_mid");
                #2 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
